// File: rtl/riscv_pkg.sv
// Shared RV32I decode definitions: opcodes, branch funct3 codes and immediate formats.
package riscv_pkg;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_REG    = 7'b0110011;

  localparam logic [2:0] F3_BEQ  = 3'd0;
  localparam logic [2:0] F3_BNE  = 3'd1;
  localparam logic [2:0] F3_BLT  = 3'd4;
  localparam logic [2:0] F3_BGE  = 3'd5;
  localparam logic [2:0] F3_BLTU = 3'd6;
  localparam logic [2:0] F3_BGEU = 3'd7;

  // FMT_X marks an opcode this stage does not recognise.
  typedef enum logic [2:0] {FMT_R, FMT_I, FMT_S, FMT_B, FMT_U, FMT_J, FMT_X} imm_fmt_e;

  function automatic imm_fmt_e fmt_of(input logic [6:0] op);
    case (op)
      OP_REG:                    return FMT_R;
      OP_LOAD, OP_IMM, OP_JALR:  return FMT_I;
      OP_STORE:                  return FMT_S;
      OP_BRANCH:                 return FMT_B;
      OP_LUI, OP_AUIPC:          return FMT_U;
      OP_JAL:                    return FMT_J;
      default:                   return FMT_X;
    endcase
  endfunction

endpackage

// File: rtl/reg_file.sv
// Register file: two asynchronous read ports, one write port, x0 hardwired to zero,
// and write-through bypass so a same-cycle writeback is visible on the read ports.
module reg_file #(
  parameter int XLEN = 32,
  parameter int NREG = 32,
  localparam int RW = $clog2(NREG)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            we,
  input  logic [RW-1:0]   waddr,
  input  logic [XLEN-1:0] wdata,
  input  logic [RW-1:0]   raddr1,
  input  logic [RW-1:0]   raddr2,
  output logic [XLEN-1:0] rdata1,
  output logic [XLEN-1:0] rdata2
);

  logic [XLEN-1:0] regs_q [NREG];
  logic [XLEN-1:0] regs_d [NREG];

  always_comb begin
    regs_d = regs_q;
    if (we && waddr != '0) regs_d[waddr] = wdata;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
    end else begin
      regs_q <= regs_d;
    end
  end

  always_comb begin
    rdata1 = regs_q[raddr1];
    if (raddr1 == '0)                   rdata1 = '0;
    else if (we && waddr == raddr1)     rdata1 = wdata;
  end

  always_comb begin
    rdata2 = regs_q[raddr2];
    if (raddr2 == '0)                   rdata2 = '0;
    else if (we && waddr == raddr2)     rdata2 = wdata;
  end

endmodule

// File: rtl/decode_stage.sv
// RV32I decode stage: operand read with bypass, immediate generation, branch resolution,
// load-use/WAW scoreboard and the ID/EX valid/ready register with flush.
module decode_stage import riscv_pkg::*; #(
  parameter int XLEN = 32,
  parameter int NREG = 32,
  localparam int RW = $clog2(NREG)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_inst,
  input  logic [XLEN-1:0] in_pc,
  input  logic            wb_en,
  input  logic [4:0]      wb_rd,
  input  logic [XLEN-1:0] wb_data,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_pc,
  output logic [XLEN-1:0] out_rs1_data,
  output logic [XLEN-1:0] out_rs2_data,
  output logic [XLEN-1:0] out_imm,
  output logic [RW-1:0]   out_rd,
  output logic [6:0]      out_opcode,
  output logic [2:0]      out_funct3,
  output logic            out_funct7b5,
  output logic            out_br_taken,
  output logic            out_illegal
);

  typedef struct packed {
    logic [XLEN-1:0] pc, rs1_data, rs2_data, imm;
    logic [RW-1:0]   rd;
    logic [6:0]      opcode;
    logic [2:0]      funct3;
    logic            funct7b5, br_taken, illegal;
  } idex_t;

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [4:0] rs1, rs2, rd;
  imm_fmt_e   fmt;
  assign opcode = in_inst[6:0];
  assign funct3 = in_inst[14:12];
  assign rs1    = in_inst[19:15];
  assign rs2    = in_inst[24:20];
  assign rd     = in_inst[11:7];
  assign fmt    = fmt_of(opcode);

  logic use_rs1, use_rs2, has_rd, is_load;
  logic rs1_ok, rs2_ok, rd_ok, wb_ok;
  logic [RW-1:0] rs1_i, rs2_i, rd_i, wb_i;
  assign use_rs1 = fmt inside {FMT_R, FMT_I, FMT_S, FMT_B};
  assign use_rs2 = fmt inside {FMT_R, FMT_S, FMT_B};
  assign has_rd  = fmt inside {FMT_R, FMT_I, FMT_U, FMT_J};
  assign is_load = (opcode == OP_LOAD);
  assign rs1_ok  = {1'b0, rs1} < 6'(NREG);
  assign rs2_ok  = {1'b0, rs2} < 6'(NREG);
  assign rd_ok   = {1'b0, rd} < 6'(NREG);
  assign wb_ok   = {1'b0, wb_rd} < 6'(NREG);
  assign rs1_i   = rs1[RW-1:0];
  assign rs2_i   = rs2[RW-1:0];
  assign rd_i    = rd[RW-1:0];
  assign wb_i    = wb_rd[RW-1:0];

  logic [XLEN-1:0] rs1_data, rs2_data;

  reg_file #(.XLEN(XLEN), .NREG(NREG)) u_rf (
    .clk    (clk),
    .rst    (rst),
    .we     (wb_en && wb_ok),
    .waddr  (wb_i),
    .wdata  (wb_data),
    .raddr1 (rs1_i),
    .raddr2 (rs2_i),
    .rdata1 (rs1_data),
    .rdata2 (rs2_data)
  );

  logic [31:0]     imm32;
  logic [XLEN-1:0] imm_ext;
  always_comb begin
    imm32 = '0;
    case (fmt)
      FMT_I:   imm32 = {{20{in_inst[31]}}, in_inst[31:20]};
      FMT_S:   imm32 = {{20{in_inst[31]}}, in_inst[31:25], in_inst[11:7]};
      FMT_B:   imm32 = {{19{in_inst[31]}}, in_inst[31], in_inst[7], in_inst[30:25],
                        in_inst[11:8], 1'b0};
      FMT_U:   imm32 = {in_inst[31:12], 12'b0};
      FMT_J:   imm32 = {{11{in_inst[31]}}, in_inst[31], in_inst[19:12], in_inst[20],
                        in_inst[30:21], 1'b0};
      default: imm32 = '0;
    endcase
    imm_ext = XLEN'($signed(imm32));
  end

  // Signed compares use signed operands directly so no overflow case exists.
  logic signed [XLEN-1:0] rs1_s, rs2_s;
  logic br_taken, f3_bad;
  assign rs1_s = rs1_data;
  assign rs2_s = rs2_data;
  always_comb begin
    br_taken = 1'b0;
    f3_bad   = 1'b0;
    if (opcode == OP_BRANCH) begin
      case (funct3)
        F3_BEQ:  br_taken = (rs1_data == rs2_data);
        F3_BNE:  br_taken = (rs1_data != rs2_data);
        F3_BLT:  br_taken = (rs1_s < rs2_s);
        F3_BGE:  br_taken = (rs1_s >= rs2_s);
        F3_BLTU: br_taken = (rs1_data < rs2_data);
        F3_BGEU: br_taken = (rs1_data >= rs2_data);
        default: f3_bad   = 1'b1;
      endcase
    end
  end

  logic illegal;
  assign illegal = (fmt == FMT_X) || f3_bad || (use_rs1 && !rs1_ok) ||
                   (use_rs2 && !rs2_ok) || (has_rd && !rd_ok);

  // A register being written back this cycle is already satisfied through the bypass.
  logic [NREG-1:0] busy_q, busy_d, clr_vec, busy_eff;
  logic            stall, xfer;
  logic            valid_q, valid_d;
  idex_t           idex_q, idex_d;

  always_comb begin
    clr_vec = '0;
    if (wb_en && wb_ok) clr_vec[wb_i] = 1'b1;
    busy_eff = busy_q & ~clr_vec;
  end

  assign stall = in_valid && ((use_rs1 && rs1_ok && busy_eff[rs1_i]) ||
                              (use_rs2 && rs2_ok && busy_eff[rs2_i]) ||
                              (is_load && rd_ok && busy_eff[rd_i]));
  assign in_ready = !stall && !flush && (!valid_q || out_ready);
  assign xfer     = in_valid && in_ready;

  always_comb begin
    busy_d = busy_eff;
    if (flush && valid_q && idex_q.opcode == OP_LOAD && idex_q.rd != '0)
      busy_d[idex_q.rd] = 1'b0;
    if (xfer && is_load && rd != 5'd0 && rd_ok)
      busy_d[rd_i] = 1'b1;
    busy_d[0] = 1'b0;
  end

  always_comb begin
    valid_d = valid_q;
    idex_d  = idex_q;
    if (flush) begin
      valid_d = 1'b0;
    end else if (xfer) begin
      valid_d         = 1'b1;
      idex_d.pc       = in_pc;
      idex_d.rs1_data = rs1_data;
      idex_d.rs2_data = rs2_data;
      idex_d.imm      = imm_ext;
      idex_d.rd       = has_rd ? rd_i : '0;
      idex_d.opcode   = opcode;
      idex_d.funct3   = funct3;
      idex_d.funct7b5 = in_inst[30];
      idex_d.br_taken = br_taken;
      idex_d.illegal  = illegal;
    end else if (out_ready) begin
      valid_d = 1'b0;
    end
  end

  // ID/EX boundary
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
      idex_q  <= '0;
      busy_q  <= '0;
    end else begin
      valid_q <= valid_d;
      idex_q  <= idex_d;
      busy_q  <= busy_d;
    end
  end

  assign out_valid    = valid_q;
  assign out_pc       = idex_q.pc;
  assign out_rs1_data = idex_q.rs1_data;
  assign out_rs2_data = idex_q.rs2_data;
  assign out_imm      = idex_q.imm;
  assign out_rd       = idex_q.rd;
  assign out_opcode   = idex_q.opcode;
  assign out_funct3   = idex_q.funct3;
  assign out_funct7b5 = idex_q.funct7b5;
  assign out_br_taken = idex_q.br_taken;
  assign out_illegal  = idex_q.illegal;

endmodule
